// File: rtl/skill_budget_sorter_pkg.sv
// Shared types for the skill budget sorter.
//   sbs_state_t       : controller states, in request order
//   sorting_element_t : one sort entry for the default configuration (W=16, N_SKILL=4).
//                       The top module declares its own parametrised copy of this layout.
package skill_budget_sorter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SORT,
    S_ACC,
    S_OUT
  } sbs_state_t;

  localparam int SBS_DEFAULT_W       = 16;
  localparam int SBS_DEFAULT_N_SKILL = 4;

  // Cost sits in the high bits so that the whole packed word compares as the
  // {cost, idx} key; idx breaks ties, which is what makes the sort stable.
  typedef struct packed {
    logic [SBS_DEFAULT_W-1:0]               cost;
    logic [$clog2(SBS_DEFAULT_N_SKILL)-1:0] idx;
  } sorting_element_t;

endpackage

// File: rtl/skill_budget_sorter_cmp_swap.sv
// sbs_cmp_swap: combinational compare-exchange of two sort elements.
// Ports:
//   en     : when low, both elements pass straight through
//   a, b   : packed {cost, idx} elements (a is the lower position)
//   lo, hi : the smaller key goes to lo and the larger key goes to hi
module sbs_cmp_swap #(
  parameter int EW = 18
) (
  input  logic          en,
  input  logic [EW-1:0] a,
  input  logic [EW-1:0] b,
  output logic [EW-1:0] lo,
  output logic [EW-1:0] hi
);

  logic swap;

  // idx values are unique within a request, so two keys are never equal.
  // The plain unsigned compare is therefore a strict and stable ordering.
  assign swap = en && (a > b);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/skill_budget_sorter.sv
// skill_budget_sorter: accepts an MP budget and N_SKILL skill costs, stably sorts
// the costs in ascending order, and spends MP greedily starting with the cheapest.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   start_valid/start_ready   : budget beat handshake (ready only while idle)
//   mp_budget                 : player MP for this request
//   cost_valid/cost_ready     : cost beat handshake (ready only while loading)
//   cost_data                 : cost of skill i, where i is the beat order
//   out_valid/out_ready       : result handshake; the result is held until it is accepted
//   out_used_cnt              : number of skills used
//   out_mp_left               : budget minus the sum of the used costs
//   out_used_mask             : bit i is set when skill i is used
//   out_rank                  : field i holds the sorted position of skill i (0 = cheapest)
module skill_budget_sorter
  import skill_budget_sorter_pkg::*;
#(
  parameter  int N_SKILL = 4,
  parameter  int W       = 16,
  localparam int IDX_W   = $clog2(N_SKILL)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [W-1:0]             mp_budget,
  input  logic                     cost_valid,
  output logic                     cost_ready,
  input  logic [W-1:0]             cost_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W:0]           out_used_cnt,
  output logic [W-1:0]             out_mp_left,
  output logic [N_SKILL-1:0]       out_used_mask,
  output logic [N_SKILL*IDX_W-1:0] out_rank
);

  localparam int               EW   = W + IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_SKILL - 1);

  typedef struct packed {
    logic [W-1:0]     cost;
    logic [IDX_W-1:0] idx;
  } elem_t;

  sbs_state_t       state;
  // pass counts load beats, then sort passes, then accumulate steps
  logic [IDX_W-1:0] pass;
  logic [W-1:0]     budget;
  logic [W:0]       sum;
  elem_t            arr     [N_SKILL];
  elem_t            arr_nxt [N_SKILL];
  logic [IDX_W-1:0] rank_q  [N_SKILL];
  logic [N_SKILL-2:0] pair_en;
  logic [EW-1:0]    pair_lo [N_SKILL-1];
  logic [EW-1:0]    pair_hi [N_SKILL-1];
  elem_t            cur;
  logic [W:0]       sum_add;
  logic             fits;

  // One comparator per neighbouring pair. Even passes enable pairs 0-1, 2-3, ...
  // and odd passes enable pairs 1-2, 3-4, ...; the enabled pairs never overlap.
  for (genvar i = 0; i < N_SKILL - 1; i++) begin : g_pair
    assign pair_en[i] = (state == S_SORT) && (pass[0] == 1'(i % 2));
    sbs_cmp_swap #(.EW(EW)) u_cmp_swap (
      .en (pair_en[i]),
      .a  (arr[i]),
      .b  (arr[i+1]),
      .lo (pair_lo[i]),
      .hi (pair_hi[i])
    );
  end

  for (genvar i = 0; i < N_SKILL; i++) begin : g_rank
    assign out_rank[i*IDX_W +: IDX_W] = rank_q[i];
  end

  always_comb begin
    for (int j = 0; j < N_SKILL; j++) arr_nxt[j] = arr[j];
    for (int j = 0; j < N_SKILL - 1; j++) begin
      if (pair_en[j]) begin
        arr_nxt[j]   = elem_t'(pair_lo[j]);
        arr_nxt[j+1] = elem_t'(pair_hi[j]);
      end
    end
  end

  // The running sum never exceeds the budget, so W+1 bits cannot overflow.
  assign cur     = arr[pass];
  assign sum_add = sum + {1'b0, cur.cost};
  assign fits    = sum_add <= {1'b0, budget};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      start_ready   <= 1'b1;
      cost_ready    <= 1'b0;
      out_valid     <= 1'b0;
      pass          <= '0;
      budget        <= '0;
      sum           <= '0;
      out_used_cnt  <= '0;
      out_mp_left   <= '0;
      out_used_mask <= '0;
      for (int k = 0; k < N_SKILL; k++) begin
        arr[k]    <= '0;
        rank_q[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            budget        <= mp_budget;
            pass          <= '0;
            sum           <= '0;
            out_used_cnt  <= '0;
            out_mp_left   <= '0;
            out_used_mask <= '0;
            for (int k = 0; k < N_SKILL; k++) rank_q[k] <= '0;
            start_ready   <= 1'b0;
            cost_ready    <= 1'b1;
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (cost_valid) begin
            arr[pass] <= '{cost: cost_data, idx: pass};
            if (pass == LAST) begin
              pass       <= '0;
              cost_ready <= 1'b0;
              state      <= S_SORT;
            end else begin
              pass <= pass + IDX_W'(1);
            end
          end
        end
        S_SORT: begin
          for (int k = 0; k < N_SKILL; k++) arr[k] <= arr_nxt[k];
          if (pass == LAST) begin
            // The last pass result is the final order, so all ranks are known here.
            for (int k = 0; k < N_SKILL; k++) rank_q[arr_nxt[k].idx] <= IDX_W'(k);
            pass  <= '0;
            state <= S_ACC;
          end else begin
            pass <= pass + IDX_W'(1);
          end
        end
        S_ACC: begin
          if (fits) begin
            sum                     <= sum_add;
            out_used_mask[cur.idx]  <= 1'b1;
            out_used_cnt            <= out_used_cnt + (IDX_W+1)'(1);
            if (pass == LAST) begin
              out_mp_left <= budget - sum_add[W-1:0];
              out_valid   <= 1'b1;
              state       <= S_OUT;
            end else begin
              pass <= pass + IDX_W'(1);
            end
          end else begin
            // The remaining elements cost at least as much as this one, so stop now.
            out_mp_left <= budget - sum[W-1:0];
            out_valid   <= 1'b1;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            start_ready <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: begin
          state       <= S_IDLE;
          start_ready <= 1'b1;
          cost_ready  <= 1'b0;
          out_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_skill_budget_sorter.sv
// Self-checking bench for skill_budget_sorter (N_SKILL=4, W=16): directed vector
// table, backpressure and reset sequences, and randomized requests checked
// against a rank-counting greedy reference model.
module tb_skill_budget_sorter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int MAX_LAT = 2 * N + 1;

  typedef struct packed {
    logic [W-1:0]        budget;
    logic [N-1:0][W-1:0] cost;
    logic [2:0]          cnt;
    logic [W-1:0]        left;
    logic [N-1:0]        mask;
    logic [N-1:0][1:0]   rank;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_valid;
  logic          start_ready;
  logic [W-1:0]  mp_budget;
  logic          cost_valid;
  logic          cost_ready;
  logic [W-1:0]  cost_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_used_cnt;
  logic [W-1:0]  out_mp_left;
  logic [N-1:0]  out_used_mask;
  logic [2*N-1:0] out_rank;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  skill_budget_sorter #(.N_SKILL(N), .W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_valid   (start_valid),
    .start_ready   (start_ready),
    .mp_budget     (mp_budget),
    .cost_valid    (cost_valid),
    .cost_ready    (cost_ready),
    .cost_data     (cost_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_used_cnt  (out_used_cnt),
    .out_mp_left   (out_mp_left),
    .out_used_mask (out_used_mask),
    .out_rank      (out_rank)
  );

  // At most one of the three handshake readies/valids may be high, since each belongs to one state.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      tests++;
      if ($countones({start_ready, cost_ready, out_valid}) > 1) begin
        fails++;
        $display("[TB] FAIL state_onehot: got %b required at most one set",
                 {start_ready, cost_ready, out_valid});
      end
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic vec_t mkVec(input int b, input int c0, input int c1, input int c2, input int c3,
                                 input int cnt, input int left, input logic [3:0] mask,
                                 input int r0, input int r1, input int r2, input int r3);
    vec_t v;
    v.budget  = W'(b);
    v.cost[0] = W'(c0); v.cost[1] = W'(c1); v.cost[2] = W'(c2); v.cost[3] = W'(c3);
    v.cnt     = 3'(cnt);
    v.left    = W'(left);
    v.mask    = mask;
    v.rank[0] = 2'(r0); v.rank[1] = 2'(r1); v.rank[2] = 2'(r2); v.rank[3] = 2'(r3);
    return v;
  endfunction

  // Reference model: rank = number of entries strictly before this one in
  // (cost, input index) order; then spend greedily in rank order.
  function automatic vec_t modelRun(input logic [W-1:0] budget, input logic [N-1:0][W-1:0] c,
                                    output int acc);
    vec_t r;
    int order [N];
    int rk;
    int sum;
    r        = '0;
    r.budget = budget;
    r.cost   = c;
    for (int i = 0; i < N; i++) begin
      rk = 0;
      for (int j = 0; j < N; j++)
        if (c[j] < c[i] || (c[j] == c[i] && j < i)) rk++;
      r.rank[i] = 2'(rk);
      order[rk] = i;
    end
    sum = 0;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      acc++;
      if (sum + int'(c[order[k]]) <= int'(budget)) begin
        sum = sum + int'(c[order[k]]);
        r.mask[order[k]] = 1'b1;
        r.cnt = r.cnt + 3'd1;
      end else begin
        break;
      end
    end
    r.left = W'(int'(budget) - sum);
    return r;
  endfunction

  task automatic sendRequest(input vec_t v, input bit gaps);
    int guard;
    guard = 0;
    while (!start_ready && guard < 40) begin @(negedge clk); guard++; end
    checkValue("start_ready_wait", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    mp_budget   = v.budget;
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (!cost_ready) checkValue("cost_ready_beat", 32'(cost_ready), 32'd1);
      cost_valid = 1'b1;
      cost_data  = v.cost[i];
      @(negedge clk);
      cost_valid = 1'b0;
      cost_data  = $urandom_range(0, 65535);
    end
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic applyStimulus(input vec_t v, input bit gaps, output int lat);
    sendRequest(v, gaps);
    waitResult(lat);
  endtask

  task automatic checkOutput(input string name, input vec_t e, input int lat, input int exp_lat);
    checkValue({name, ".out_valid"}, 32'(out_valid), 32'd1);
    checkValue({name, ".cnt"},  32'(out_used_cnt),  32'(e.cnt));
    checkValue({name, ".left"}, 32'(out_mp_left),   32'(e.left));
    checkValue({name, ".mask"}, 32'(out_used_mask), 32'(e.mask));
    checkValue({name, ".rank"}, 32'(out_rank),      32'(e.rank));
    checkValue({name, ".latency"}, 32'(lat), 32'(exp_lat));
    tests++;
    if (lat > MAX_LAT) begin
      fails++;
      $display("[TB] FAIL %s.latency_bound: got %0d required <= %0d", name, lat, MAX_LAT);
    end
  endtask

  task automatic acceptResult(input string name, input int delay);
    repeat (delay) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkValue({name, ".drop_valid"}, 32'(out_valid), 32'd0);
    checkValue({name, ".idle_ready"}, 32'(start_ready), 32'd1);
  endtask

  vec_t table_v [4];
  vec_t t1;
  vec_t e;
  vec_t rv;
  int   acc;
  int   lat;
  bit   seen;

  initial begin
    table_v[0] = mkVec(100, 30, 10, 50, 20, 3, 40, 4'b1011, 2, 0, 3, 1);
    table_v[1] = mkVec(40, 20, 20, 20, 20, 2, 0, 4'b0011, 0, 1, 2, 3);
    table_v[2] = mkVec(0, 0, 5, 0, 7, 2, 0, 4'b0101, 0, 2, 1, 3);
    table_v[3] = mkVec(65535, 65535, 65535, 65535, 65535, 1, 0, 4'b0001, 0, 1, 2, 3);
    t1 = table_v[0];

    rst = 1'b1; start_valid = 1'b0; mp_budget = '0; cost_valid = 1'b0;
    cost_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkValue("reset.start_ready", 32'(start_ready), 32'd1);
    checkValue("reset.cost_ready",  32'(cost_ready),  32'd0);
    checkValue("reset.out_valid",   32'(out_valid),   32'd0);
    checkValue("reset.cnt",         32'(out_used_cnt), 32'd0);
    checkValue("reset.left",        32'(out_mp_left),  32'd0);
    checkValue("reset.mask",        32'(out_used_mask), 32'd0);
    checkValue("reset.rank",        32'(out_rank),     32'd0);

    // Directed table T1..T4
    for (int t = 0; t < 4; t++) begin
      e = modelRun(table_v[t].budget, table_v[t].cost, acc);
      applyStimulus(table_v[t], 1'b0, lat);
      checkOutput($sformatf("T%0d", t + 1), table_v[t], lat, N + acc);
      acceptResult($sformatf("T%0d", t + 1), 0);
    end

    // T5: backpressure with a stray start pulse while busy
    e = modelRun(t1.budget, t1.cost, acc);
    applyStimulus(t1, 1'b0, lat);
    checkOutput("T5", t1, lat, N + acc);
    for (int c = 0; c < 5; c++) begin
      start_valid = (c == 2);
      mp_budget   = 16'd7;
      @(negedge clk);
      start_valid = 1'b0;
      checkValue("T5.hold_valid", 32'(out_valid),     32'd1);
      checkValue("T5.hold_cnt",   32'(out_used_cnt),  32'(t1.cnt));
      checkValue("T5.hold_left",  32'(out_mp_left),   32'(t1.left));
      checkValue("T5.hold_mask",  32'(out_used_mask), 32'(t1.mask));
      checkValue("T5.hold_rank",  32'(out_rank),      32'(t1.rank));
    end
    acceptResult("T5", 0);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checkValue("T5.single_result", 32'(seen), 32'd0);
    checkValue("T5.still_idle", 32'(start_ready), 32'd1);

    // T6: reset while sorting aborts the request
    sendRequest(t1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkValue("T6.out_valid",   32'(out_valid),   32'd0);
    checkValue("T6.start_ready", 32'(start_ready), 32'd1);
    checkValue("T6.cost_ready",  32'(cost_ready),  32'd0);
    seen = 1'b0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checkValue("T6.no_partial", 32'(seen), 32'd0);
    e = modelRun(t1.budget, t1.cost, acc);
    applyStimulus(t1, 1'b0, lat);
    checkOutput("T6", t1, lat, N + acc);
    acceptResult("T6", 0);

    // Randomized requests against the reference model
    for (int r = 0; r < 40; r++) begin
      logic [W-1:0]        b;
      logic [N-1:0][W-1:0] c;
      for (int i = 0; i < N; i++)
        c[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 30));
      b  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 65535)) : W'($urandom_range(0, 90));
      rv = modelRun(b, c, acc);
      applyStimulus(rv, 1'b1, lat);
      checkOutput($sformatf("R%0d", r), rv, lat, N + acc);
      acceptResult($sformatf("R%0d", r), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
